// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU sequencer slice.
// Holds the sequencer state enum and the instruction/opcode geometry.
package cpu_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 4;

  // Opcode that parks the sequencer until the next reset.
  localparam logic [OPCODE_W-1:0] HALT_OP_DEFAULT = 4'hF;

  // Explicit encodings so that unused codes (5..7) fall into the recovery path.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_HALT      = 3'd3,
    ST_STEP_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter register for the sequencer.
// Presets to RESET_PC, then either increments (wrapping modulo 2^ADDR_W)
// or loads a branch target when the sequencer retires an instruction.
module pc_unit #(
  parameter int                ADDR_W   = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_advance,
  input  logic              i_branch,
  input  logic [ADDR_W-1:0] i_target,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] PC_STEP = 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: hold, sequential step (natural wrap at the top), or branch.
  always_comb begin
    pc_d = pc_q;
    if (i_advance) begin
      pc_d = i_branch ? i_target : (pc_q + PC_STEP);
    end
  end

  // PC register with asynchronous preset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign o_pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute control FSM, one instruction in flight.
// Optional feature: define CPU_SEQ_SINGLE_STEP_EN to add i_step / i_step_mode,
// which park the FSM in STEP_WAIT before every fetch until i_step rises.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                  ADDR_W   = 28,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [OPCODE_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_req,
  input  logic                i_mem_ack,
  input  logic [INSTR_W-1:0]  i_mem_data,
  output logic [INSTR_W-1:0]  o_instruction,
  output logic                o_decode_enable,
  input  logic                i_decode_completed,
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_exec_start,
  input  logic                i_exec_done,
  input  logic                i_branch_taken,
  input  logic [ADDR_W-1:0]   i_branch_target,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic                i_step,
  input  logic                i_step_mode,
`endif
  output logic                o_halted
);

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 decode_en_q, decode_en_d;
  logic                 exec_start_q, exec_start_d;
  logic                 halted_q, halted_d;
  logic                 pc_advance;
  logic                 step_mode;
  logic                 step_rise;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step_prev_q;
  assign step_mode = i_step_mode;
  assign step_rise = i_step & ~step_prev_q;

  // Remember last i_step level for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_prev_q <= 1'b0;
    end else begin
      step_prev_q <= i_step;
    end
  end
`else
  assign step_mode = 1'b0;
  assign step_rise = 1'b0;
`endif

  // Next-state and next-output logic; outputs are derived from the next state
  // so every control output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_advance = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // An ack only counts while our request is actually on the bus.
        if (mem_req_q && i_mem_ack) begin
          instr_d = i_mem_data;
          state_d = ST_DECODE;
        end else if (!mem_req_q && step_mode) begin
          // First fetch after reset is also gated by the step control.
          state_d = ST_STEP_WAIT;
        end
      end
      ST_DECODE: begin
        if (i_decode_completed) begin
          state_d = (i_opcode == HALT_OP) ? ST_HALT : ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (i_exec_done) begin
          pc_advance = 1'b1;
          state_d    = step_mode ? ST_STEP_WAIT : ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_STEP_WAIT: begin
        if (step_rise || !step_mode) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    mem_req_d    = (state_d == ST_FETCH);
    decode_en_d  = (state_d == ST_DECODE);
    exec_start_d = (state_q == ST_DECODE) && (state_d == ST_EXEC);
    halted_d     = (state_d == ST_HALT);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      mem_req_q    <= 1'b0;
      instr_q      <= '0;
      decode_en_q  <= 1'b0;
      exec_start_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      instr_q      <= instr_d;
      decode_en_q  <= decode_en_d;
      exec_start_q <= exec_start_d;
      halted_q     <= halted_d;
    end
  end

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .i_advance (pc_advance),
    .i_branch  (i_branch_taken),
    .i_target  (i_branch_target),
    .o_pc      (o_mem_addr)
  );

  assign o_mem_req       = mem_req_q;
  assign o_instruction   = instr_q;
  assign o_decode_enable = decode_en_q;
  assign o_exec_start    = exec_start_q;
  assign o_halted        = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer.
// Plays memory, decode and execute units; directed table plus random program.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [27:0] o_mem_addr;
  logic        o_mem_req;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic [31:0] o_instruction;
  logic        o_decode_enable;
  logic        i_decode_completed = 1'b0;
  logic [3:0]  i_opcode = '0;
  logic        o_exec_start;
  logic        i_exec_done = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [27:0] i_branch_target = '0;
  logic        o_halted;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic        i_step = 1'b0;
  logic        i_step_mode = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  cpu_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .o_mem_addr         (o_mem_addr),
    .o_mem_req          (o_mem_req),
    .i_mem_ack          (i_mem_ack),
    .i_mem_data         (i_mem_data),
    .o_instruction      (o_instruction),
    .o_decode_enable    (o_decode_enable),
    .i_decode_completed (i_decode_completed),
    .i_opcode           (i_opcode),
    .o_exec_start       (o_exec_start),
    .i_exec_done        (i_exec_done),
    .i_branch_taken     (i_branch_taken),
    .i_branch_target    (i_branch_target),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .i_step             (i_step),
    .i_step_mode        (i_step_mode),
`endif
    .o_halted           (o_halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          mem_wait;
    int          dec_wait;
    int          exec_wait;
    logic        taken;
    logic [27:0] target;
    logic [27:0] exp_addr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int k = 0;
    while (o_mem_req !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("req_wait", {63'd0, o_mem_req}, 64'd1);
  endtask

  // One full instruction: fetch handshake, decode handshake, execute handshake.
  task automatic do_instr(input vec_t v);
    int starts = 0;
    wait_req();
    chk("fetch_addr", {36'd0, o_mem_addr}, {36'd0, v.exp_addr});
    repeat (v.mem_wait) @(negedge clk);
    chk("req_held", {63'd0, o_mem_req}, 64'd1);
    i_mem_ack  = 1'b1;
    i_mem_data = v.word;
    @(negedge clk);
    i_mem_ack  = 1'b0;
    i_mem_data = $urandom;
    chk("instr_reg", {32'd0, o_instruction}, {32'd0, v.word});
    chk("decode_en", {63'd0, o_decode_enable}, 64'd1);
    chk("req_drop", {63'd0, o_mem_req}, 64'd0);
    repeat (v.dec_wait) @(negedge clk);
    chk("decode_hold", {63'd0, o_decode_enable}, 64'd1);
    i_opcode           = v.word[31:28];
    i_decode_completed = 1'b1;
    @(negedge clk);
    i_decode_completed = 1'b0;
    i_opcode           = 4'($urandom);
    n_txn++;
    $display("txn %0d addr=%h word=%h taken=%0d target=%h", n_txn, v.exp_addr, v.word, v.taken, v.target);
    if (v.word[31:28] == 4'hF) begin
      chk("halted", {63'd0, o_halted}, 64'd1);
      chk("halt_no_start", {63'd0, o_exec_start}, 64'd0);
      return;
    end
    chk("exec_start", {63'd0, o_exec_start}, 64'd1);
    chk("decode_off", {63'd0, o_decode_enable}, 64'd0);
    repeat (v.exec_wait) begin
      @(negedge clk);
      if (o_exec_start) starts++;
    end
    i_exec_done     = 1'b1;
    i_branch_taken  = v.taken;
    i_branch_target = v.target;
    @(negedge clk);
    i_exec_done     = 1'b0;
    i_branch_taken  = 1'($urandom);
    i_branch_target = 28'($urandom);
    if (o_exec_start) starts++;
    chk("start_pulse_once", 64'(starts), 64'd0);
  endtask

  vec_t tbl[7];
  vec_t rv;
  logic [27:0] pc_model;
  int bad;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{32'h1000_0005, 2, 0, 1, 1'b0, 28'h0,        28'h0};
    tbl[1] = '{32'h2000_0001, 0, 1, 1, 1'b0, 28'h0,        28'h1};
    tbl[2] = '{32'h3000_0002, 1, 0, 1, 1'b0, 28'h0,        28'h2};
    tbl[3] = '{32'h4000_0003, 0, 0, 0, 1'b1, 28'h00000A0,  28'h3};
    tbl[4] = '{32'h5000_00A0, 3, 2, 2, 1'b1, 28'hFFFFFFF,  28'h00000A0};
    tbl[5] = '{32'h6000_FFFF, 0, 0, 1, 1'b0, 28'h0,        28'hFFFFFFF};
    tbl[6] = '{32'h7000_0000, 1, 0, 0, 1'b0, 28'h0,        28'h0};

    // Reset state while reset is held.
    #3;
    chk("rst_req", {63'd0, o_mem_req}, 64'd0);
    chk("rst_addr", {36'd0, o_mem_addr}, 64'd0);
    chk("rst_instr", {32'd0, o_instruction}, 64'd0);
    chk("rst_ctrl", {61'd0, o_decode_enable, o_exec_start, o_halted}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) do_instr(tbl[i]);

    // Random program against an arithmetic PC model.
    pc_model = 28'h1;
    for (int i = 0; i < 40; i++) begin
      rv.word      = {4'($urandom_range(0, 14)), 28'($urandom)};
      rv.mem_wait  = $urandom_range(0, 3);
      rv.dec_wait  = $urandom_range(0, 2);
      rv.exec_wait = $urandom_range(0, 3);
      rv.taken     = 1'($urandom);
      rv.target    = 28'($urandom);
      rv.exp_addr  = pc_model;
      do_instr(rv);
      pc_model = rv.taken ? rv.target : pc_model + 28'd1;
    end

    // HALT: no further requests or starts.
    rv = '{32'hF000_0000, 1, 0, 0, 1'b0, 28'h0, pc_model};
    do_instr(rv);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_mem_req || o_exec_start || !o_halted) bad++;
    end
    chk("halt_quiet", 64'(bad), 64'd0);

    // Reset mid-fetch: request drops asynchronously.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_req();
    #2;
    reset = 1'b1;
    #1;
    chk("async_req_drop", {63'd0, o_mem_req}, 64'd0);
    chk("async_halt_clr", {63'd0, o_halted}, 64'd0);
    @(negedge clk);
    reset      = 1'b0;
    // Late ack arriving while no request is outstanding must be ignored.
    i_mem_ack  = 1'b1;
    i_mem_data = 32'hDEAD_BEEF;
    @(negedge clk);
    i_mem_ack  = 1'b0;
    chk("late_ack_instr", {32'd0, o_instruction}, 64'd0);
    chk("late_ack_decode", {63'd0, o_decode_enable}, 64'd0);
    rv = '{32'h1234_5678, 0, 0, 0, 1'b0, 28'h0, 28'h0};
    do_instr(rv);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    i_step_mode = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_mem_req) bad++;
    end
    chk("step_gate0", 64'(bad), 64'd0);
    i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
    rv = '{32'h2222_0000, 0, 0, 0, 1'b0, 28'h0, 28'h0};
    do_instr(rv);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_mem_req) bad++;
    end
    chk("step_gate1", 64'(bad), 64'd0);
    i_step = 1'b1;
    @(negedge clk);
    i_step = 1'b0;
    rv = '{32'h3333_0000, 0, 0, 0, 1'b0, 28'h0, 28'h1};
    do_instr(rv);
    i_step_mode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
